// File: rtl/shifter_arbiter.sv
// Two-port round-robin front end that shares one 32-bit barrel shifter.
// Every operation runs IDLE -> SHIFT -> RESP. Only DATA_W = 32 is supported.
module Barrel_Shifter (
  input  logic [31:0] din_i,
  input  logic [4:0]  amt_i,
  input  logic        dir_i,
  output logic [31:0] dout_o
);
  logic [5:0][31:0] stg;
  logic             fill;

  assign fill   = dir_i & din_i[31];
  assign stg[0] = din_i;

  // Log shifter: stage s shifts by 2**s when amt bit s is set.
  for (genvar s = 0; s < 5; s++) begin : g_stage
    localparam int SH = 1 << s;
    assign stg[s+1] = !amt_i[s] ? stg[s] :
                      dir_i     ? {{SH{fill}}, stg[s][31:SH]} :
                                  {stg[s][31-SH:0], {SH{1'b0}}};
  end

  assign dout_o = stg[5];
endmodule

module shifter_arbiter #(
  parameter int DATA_W = 32,
  parameter int AMT_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              REQ0,
  input  logic              DIR0,
  input  logic [AMT_W-1:0]  AMT0,
  input  logic [DATA_W-1:0] DIN0,
  output logic              GNT0,
  input  logic              REQ1,
  input  logic              DIR1,
  input  logic [AMT_W-1:0]  AMT1,
  input  logic [DATA_W-1:0] DIN1,
  output logic              GNT1,
  output logic              RES_VALID,
  output logic              RES_ID,
  output logic [DATA_W-1:0] RES_DATA,
  input  logic              RES_READY,
  output logic [CNT_W-1:0]  OP_CNT
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  typedef struct packed {
    logic              dir;
    logic [AMT_W-1:0]  amt;
    logic [DATA_W-1:0] din;
  } op_t;

  logic [1:0]        state_q, state_d;
  logic              last_q, last_d;
  logic              id_q, id_d;
  op_t               op_q, op_d;
  logic              res_valid_q, res_valid_d;
  logic              res_id_q, res_id_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic [CNT_W-1:0]  op_cnt_q, op_cnt_d;
  logic [1:0]        gnt;
  logic [DATA_W-1:0] sh_out;
  op_t [1:0]         req_op;

  assign req_op[0] = '{dir: DIR0, amt: AMT0, din: DIN0};
  assign req_op[1] = '{dir: DIR1, amt: AMT1, din: DIN1};

  // Under contention the side that did not win last time goes first.
  always_comb begin
    gnt = 2'b00;
    if (Rst_n && state_q == IDLE) begin
      if (REQ0 && (!REQ1 || last_q)) gnt[0] = 1'b1;
      else if (REQ1)                 gnt[1] = 1'b1;
    end
  end

  Barrel_Shifter u_shifter (
    .din_i  (op_q.din),
    .amt_i  (op_q.amt),
    .dir_i  (op_q.dir),
    .dout_o (sh_out)
  );

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    id_d        = id_q;
    op_d        = op_q;
    res_valid_d = res_valid_q;
    res_id_d    = res_id_q;
    res_data_d  = res_data_q;
    op_cnt_d    = op_cnt_q;
    case (state_q)
      IDLE: if (|gnt) begin
        op_d    = req_op[gnt[1]];
        id_d    = gnt[1];
        last_d  = gnt[1];
        state_d = SHIFT;
      end
      SHIFT: begin
        res_data_d  = sh_out;
        res_id_d    = id_q;
        res_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: if (RES_READY) begin
        res_valid_d = 1'b0;
        op_cnt_d    = op_cnt_q + CNT_W'(1);
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      id_q        <= 1'b0;
      op_q        <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= 1'b0;
      res_data_q  <= '0;
      op_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      id_q        <= id_d;
      op_q        <= op_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_data_q  <= res_data_d;
      op_cnt_q    <= op_cnt_d;
    end
  end

  assign GNT0      = gnt[0];
  assign GNT1      = gnt[1];
  assign RES_VALID = res_valid_q;
  assign RES_ID    = res_id_q;
  assign RES_DATA  = res_data_q;
  assign OP_CNT    = op_cnt_q;
endmodule

// File: doc/shifter_arbiter.md
Name: shifter_arbiter

Overview:
- Shares one 32-bit Barrel_Shifter instance between two requesters (port 0, port 1).
- Each operation is captured on a REQ/GNT handshake and executed in a registered pipeline step.
- The result is returned on a valid/ready response channel tagged with the requester ID.
- Sits between the two datapath clients and the shifter; the shifter is instantiated inside this block.

Parameters:
- DATA_W, 32, operand/result width; the Barrel_Shifter is fixed at 32, so any other value is unsupported.
- AMT_W, 5, shift-amount width (log2 of DATA_W).
- CNT_W, 16, width of the completed-operation counter.

Ports:
- Clk  input  1  system clock, rising-edge.
- Rst_n  input  1  asynchronous, active-low reset.
- REQ0  input  1  requester 0 has an operation pending; held high with operands stable until GNT0.
- DIR0  input  1  requester 0 direction: 1 = arithmetic right, 0 = logical left.
- AMT0  input  AMT_W  requester 0 shift amount.
- DIN0  input  DATA_W  requester 0 operand.
- GNT0  output  1  requester 0 operands captured at this rising edge.
- REQ1, DIR1, AMT1, DIN1, GNT1  as above for requester 1.
- RES_VALID  output  1  result available.
- RES_ID  output  1  requester that owns RES_DATA.
- RES_DATA  output  DATA_W  shifted result.
- RES_READY  input  1  consumer accepts the result.
- OP_CNT  output  CNT_W  number of completed (accepted) results.

Behaviour:
- Reset: asynchronous assertion when Rst_n=0.
  - FSM = IDLE; GNT0=GNT1=0; RES_VALID=0; RES_ID=0; RES_DATA=0; OP_CNT=0.
  - Internal operand registers = 0; round-robin pointer LAST=1, so requester 0 wins first.
- Reset asserted mid-operation aborts everything; no result is produced for the in-flight op.
- Shifter semantics:
  - DIR=1: arithmetic right; sign bit replicated, 0x80000000>>4 = 0xF8000000.
  - DIR=0: logical left; zero fill.
  - AMT=0 passes the operand through.
- FSM states: IDLE, SHIFT, RESP.
- IDLE:
  - GNTx is combinational: high only in IDLE for the selected requester.
  - Selection: if exactly one REQ is high, grant it. If both are high, grant the requester that is not LAST.
  - At the rising edge with GNTx=1: latch DIRx/AMTx/DINx, record ID=x, update LAST=x, go to SHIFT.
  - No REQ: stay in IDLE, GNT0=GNT1=0.
- SHIFT (exactly 1 cycle):
  - Latched operands drive the shifter.
  - At the edge: RES_DATA <= shifter output, RES_ID <= ID, RES_VALID <= 1, go to RESP.
- RESP:
  - RES_VALID, RES_ID and RES_DATA are held stable until RES_READY=1 at a rising edge.
  - On that edge: RES_VALID <= 0, OP_CNT <= OP_CNT+1 (wraps modulo 2^CNT_W), go to IDLE.
- Latency: grant edge N, RES_VALID high after edge N+1. Earliest next grant is the cycle after acceptance.
- Throughput: at most 1 operation per 3 cycles.
- GNT is never asserted outside IDLE; REQs arriving during SHIFT/RESP wait.
- Requesters may drop REQ before being granted; the block never grants a requester whose REQ is low.
- If RES_READY is already high when RES_VALID rises, the result is accepted at the next edge (one RESP cycle).

Test Plan:
- Reset mid-RESP:
  - Drive Rst_n=0 while RES_VALID=1 -> all outputs 0 immediately without a clock, OP_CNT=0.
  - After release -> next REQ0 granted from IDLE.
- Single requester, arithmetic right, RES_READY tied 1:
  - REQ0, DIR0=1, DIN0=0x80000000, sweep AMT0 0..31 -> RES_DATA = sign-extended mask (AMT 4 -> 0xF8000000, AMT 31 -> 0xFFFFFFFF), RES_ID=0.
  - RES_VALID occurs 2 edges after each grant; OP_CNT=32 at end.
- Positive right and left:
  - REQ1, DIR1=1, DIN1=0x40000000, AMT1=30 -> 0x00000001.
  - DIR1=0, DIN1=0x00000001, AMT1=31 -> 0x80000000; RES_ID=1 both.
- Contention:
  - REQ0 and REQ1 held high continuously, RES_READY=1 -> grants alternate 0,1,0,1.
  - RES_ID sequence matches; no grant is issued during SHIFT/RESP.
- Backpressure:
  - RES_READY=0 for 5 cycles after RES_VALID -> RES_DATA/RES_ID stable, GNT0=GNT1=0 throughout, OP_CNT unchanged.
  - Raise RES_READY -> OP_CNT increments by 1, next grant issued one cycle later.
- Counter wrap:
  - Preload by running 65536 ops (or force OP_CNT=0xFFFF) -> next accepted result gives OP_CNT=0x0000.
